// File: rtl/location_scheduler.sv
// Frame-level sequencer: loads one labelled frame into the location algorithm, starts it and latches its results.
// Optional WAIT_DONE watchdog enabled by defining LOC_SCHED_TIMEOUT_EN.
module location_scheduler #(
  parameter int WIDTH          = 80,
  parameter int HEIGHT         = 60,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         enable,
  input  logic         in_valid,
  input  logic         in_sof,
  input  logic [1:0]   in_data,
  output logic         in_ready,
  output logic         alg_write,
  output logic [1:0]   alg_write_data,
  output logic         alg_start,
  input  logic         alg_done,
  input  logic [191:0] alg_locations,
  input  logic [2:0]   reg_addr,
  output logic [31:0]  reg_rdata,
  output logic         busy,
  output logic         irq,
  input  logic         irq_clear
);

  localparam int         FSIZE   = WIDTH * HEIGHT;
  localparam logic [12:0] FSIZE_C = 13'(FSIZE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SOF,
    S_LOAD,
    S_START,
    S_WAIT_DONE,
    S_CAPTURE
  } state_t;

  state_t      state_reg, state_next;
  logic [12:0] pix_cnt_reg, pix_cnt_next;
  logic        write_next;
  logic        sync_set;
  logic        capture;
  logic        timeout_hit;
  logic        alg_write_reg;
  logic [1:0]  alg_write_data_reg;
  logic        alg_start_reg;
  logic [15:0] frame_count_reg;
  logic        irq_reg;
  logic        sync_err_reg;
  logic        timeout_err;
  logic [31:0] loc_reg [6];

`ifdef LOC_SCHED_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] to_cnt_reg;
  logic        timeout_err_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_reg <= '0;
    end else if (state_reg == S_WAIT_DONE) begin
      to_cnt_reg <= to_cnt_reg + 16'd1;
    end else begin
      to_cnt_reg <= '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timeout_err_reg <= 1'b0;
    end else if (timeout_hit) begin
      timeout_err_reg <= 1'b1;
    end else if (irq_clear) begin
      timeout_err_reg <= 1'b0;
    end
  end

  assign timeout_err = timeout_err_reg;
`else
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_next   = state_reg;
    pix_cnt_next = pix_cnt_reg;
    in_ready     = 1'b0;
    busy         = 1'b0;
    write_next   = 1'b0;
    sync_set     = 1'b0;
    capture      = 1'b0;
    timeout_hit  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (enable) state_next = S_WAIT_SOF;
      end
      S_WAIT_SOF: begin
        in_ready = 1'b1;
        if (in_valid && in_sof) begin
          write_next   = 1'b1;
          pix_cnt_next = 13'd1;
          state_next   = S_LOAD;
        end else if (!enable) begin
          state_next = S_IDLE;
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          write_next = 1'b1;
          // A mid-frame SOF restarts the frame from pixel 0
          if (in_sof) begin
            sync_set     = 1'b1;
            pix_cnt_next = 13'd1;
          end else begin
            pix_cnt_next = pix_cnt_reg + 13'd1;
            if (pix_cnt_reg + 13'd1 == FSIZE_C) state_next = S_START;
          end
        end
      end
      S_START: begin
        busy       = 1'b1;
        state_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        busy = 1'b1;
        if (alg_done) begin
          state_next = S_CAPTURE;
        end
`ifdef LOC_SCHED_TIMEOUT_EN
        else if (to_cnt_reg == TO_LAST) begin
          timeout_hit = 1'b1;
          state_next  = enable ? S_WAIT_SOF : S_IDLE;
        end
`endif
      end
      S_CAPTURE: begin
        capture    = 1'b1;
        state_next = enable ? S_WAIT_SOF : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Start is registered off the START state so it lands one cycle after the final write
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg          <= S_IDLE;
      pix_cnt_reg        <= '0;
      alg_write_reg      <= 1'b0;
      alg_write_data_reg <= '0;
      alg_start_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pix_cnt_reg   <= pix_cnt_next;
      alg_write_reg <= write_next;
      alg_start_reg <= (state_reg == S_START);
      if (write_next) alg_write_data_reg <= in_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_loc
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          loc_reg[gi] <= '0;
        end else if (capture) begin
          loc_reg[gi] <= alg_locations[gi*32 +: 32];
        end
      end
    end
  endgenerate

  // Set beats clear when both land in the same cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_count_reg <= '0;
      irq_reg         <= 1'b0;
      sync_err_reg    <= 1'b0;
    end else begin
      if (capture) frame_count_reg <= frame_count_reg + 16'd1;
      if (capture || timeout_hit) irq_reg <= 1'b1;
      else if (irq_clear)         irq_reg <= 1'b0;
      if (sync_set)               sync_err_reg <= 1'b1;
      else if (irq_clear)         sync_err_reg <= 1'b0;
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      3'd0:    reg_rdata = loc_reg[0];
      3'd1:    reg_rdata = loc_reg[1];
      3'd2:    reg_rdata = loc_reg[2];
      3'd3:    reg_rdata = loc_reg[3];
      3'd4:    reg_rdata = loc_reg[4];
      3'd5:    reg_rdata = loc_reg[5];
      3'd6:    reg_rdata = {frame_count_reg, 13'b0, timeout_err, sync_err_reg, busy};
      default: reg_rdata = {19'b0, pix_cnt_reg};
    endcase
  end

  assign alg_write      = alg_write_reg;
  assign alg_write_data = alg_write_data_reg;
  assign alg_start      = alg_start_reg;
  assign irq            = irq_reg;

endmodule
